// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit splitting accesses into narrow bus beats
// Optional: define LSU_MISALIGN_SPLIT_EN to accept misaligned accesses as multi-beat transfers.

`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef ME_NOP_OP
`define ME_NOP_OP 8'b00000000
`endif
`ifndef EX_LB_OP
`define EX_LB_OP  8'b11100000
`endif
`ifndef EX_LH_OP
`define EX_LH_OP  8'b11100001
`endif
`ifndef EX_LW_OP
`define EX_LW_OP  8'b11100011
`endif
`ifndef EX_LBU_OP
`define EX_LBU_OP 8'b11100100
`endif
`ifndef EX_LHU_OP
`define EX_LHU_OP 8'b11100101
`endif
`ifndef EX_SB_OP
`define EX_SB_OP  8'b11101000
`endif
`ifndef EX_SH_OP
`define EX_SH_OP  8'b11101001
`endif
`ifndef EX_SW_OP
`define EX_SW_OP  8'b11101011
`endif
`ifndef NOPRegAddr
`define NOPRegAddr 5'b00000
`endif

module mem_lsu #(
    parameter int BUS_BYTES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`AluOpBus]       aluop_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [31:0]            wdata_i,
    input  logic [4:0]             wd_i,
    input  logic                   wreg_i,
    input  logic                   hold_i,
    output logic [4:0]             wd_o,
    output logic                   wreg_o,
    output logic [31:0]            wdata_o,
    output logic                   stall_req_o,
    output logic                   misalign_o,
    output logic                   ram_req_o,
    output logic                   ram_we_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [8*BUS_BYTES-1:0] ram_wdata_o,
    output logic [BUS_BYTES-1:0]   ram_be_o,
    input  logic [8*BUS_BYTES-1:0] ram_rdata_i,
    input  logic                   ram_done_i
);

    localparam int BW = 8 * BUS_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    function automatic logic [2:0] op_size(input logic [`AluOpBus] op);
        case (op)
            `EX_LB_OP, `EX_LBU_OP, `EX_SB_OP: op_size = 3'd1;
            `EX_LH_OP, `EX_LHU_OP, `EX_SH_OP: op_size = 3'd2;
            `EX_LW_OP, `EX_SW_OP:             op_size = 3'd4;
            default:                          op_size = 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [`AluOpBus] op);
        is_store = (op == `EX_SB_OP) || (op == `EX_SH_OP) || (op == `EX_SW_OP);
    endfunction

    function automatic logic is_signed(input logic [`AluOpBus] op);
        is_signed = (op == `EX_LB_OP) || (op == `EX_LH_OP);
    endfunction

    // Access byte carried by lane l of beat k; out of range means lane unused.
    function automatic int byte_idx(input logic [1:0] k, input logic [1:0] off, input int l);
        byte_idx = int'(k) * BUS_BYTES + l - int'(off);
    endfunction

    function automatic logic [BUS_BYTES-1:0] beat_be(input logic [1:0] off,
                                                     input logic [2:0] size,
                                                     input logic [1:0] k);
        int j;
        beat_be = '0;
        for (int l = 0; l < BUS_BYTES; l++) begin
            j = byte_idx(k, off, l);
            if (j >= 0 && j < int'(size)) beat_be[l] = 1'b1;
        end
    endfunction

    function automatic logic [BW-1:0] beat_wl(input logic [1:0]  off,
                                              input logic [2:0]  size,
                                              input logic [1:0]  k,
                                              input logic [31:0] data);
        int j;
        beat_wl = '0;
        for (int l = 0; l < BUS_BYTES; l++) begin
            j = byte_idx(k, off, l);
            if (j >= 0 && j < int'(size)) beat_wl[8*l +: 8] = data[8*j +: 8];
        end
    endfunction

    logic [2:0]        w_in_size;
    logic              w_in_mem;
    logic              w_in_store;
    logic              w_in_mis;
    logic [1:0]        w_in_off;
    logic [ADDR_W-1:0] w_in_base;
    logic [2:0]        w_in_nb;

    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_off;
    logic [2:0]        r_size;
    logic [2:0]        r_nb;
    logic [31:0]       r_sdata;
    logic              r_load;
    logic              r_signed;
    logic [1:0]        r_beat;
    logic [31:0]       r_asm;
    logic              r_mis;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [BUS_BYTES-1:0] r_be;
    logic [BW-1:0]     r_wl;

    logic              w_last;
    logic              w_beat_done;
    logic [31:0]       w_asm_nxt;
    logic [31:0]       w_ext;

    assign w_in_size  = op_size(aluop_i);
    assign w_in_mem   = (w_in_size != 3'd0);
    assign w_in_store = is_store(aluop_i);
    assign w_in_off   = addr_i[1:0] & 2'(BUS_BYTES - 1);
    assign w_in_base  = addr_i & ~ADDR_W'(BUS_BYTES - 1);
    assign w_in_nb    = 3'((4'(w_in_off) + 4'(w_in_size) + 4'(BUS_BYTES - 1)) >> $clog2(BUS_BYTES));

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_in_mis = 1'b0;
`else
    assign w_in_mis = ((w_in_size == 3'd2) && addr_i[0]) ||
                      ((w_in_size == 3'd4) && (addr_i[1:0] != 2'b00));
`endif

    assign w_last      = ({1'b0, r_beat} == (r_nb - 3'd1));
    assign w_beat_done = (r_state == S_ACCESS) && r_req && ram_done_i;

    always_comb begin
        w_asm_nxt = r_asm;
        for (int l = 0; l < BUS_BYTES; l++) begin
            if (byte_idx(r_beat, r_off, l) >= 0 && byte_idx(r_beat, r_off, l) < int'(r_size))
                w_asm_nxt[8*byte_idx(r_beat, r_off, l) +: 8] = ram_rdata_i[8*l +: 8];
        end
    end

    always_comb begin
        case (r_size)
            3'd1:    w_ext = {{24{r_signed & r_asm[7]}}, r_asm[7:0]};
            3'd2:    w_ext = {{16{r_signed & r_asm[15]}}, r_asm[15:0]};
            default: w_ext = r_asm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_in_mem) w_next = w_in_mis ? S_DONE : S_ACCESS;
            S_ACCESS: if (w_beat_done && w_last) w_next = S_DONE;
            S_DONE:   if (!hold_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Beat 0 is issued straight from the inputs so the request is up in the first ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base   <= '0;
            r_off    <= '0;
            r_size   <= '0;
            r_nb     <= '0;
            r_sdata  <= '0;
            r_load   <= 1'b0;
            r_signed <= 1'b0;
            r_beat   <= '0;
            r_asm    <= '0;
            r_mis    <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wl     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_mem) begin
                        r_base   <= w_in_base;
                        r_off    <= w_in_off;
                        r_size   <= w_in_size;
                        r_nb     <= w_in_nb;
                        r_sdata  <= wdata_i;
                        r_load   <= !w_in_store;
                        r_signed <= is_signed(aluop_i);
                        r_beat   <= 2'd0;
                        r_asm    <= '0;
                        r_mis    <= w_in_mis;
                        r_we     <= w_in_store;
                        if (!w_in_mis) begin
                            r_req  <= 1'b1;
                            r_addr <= w_in_base;
                            r_be   <= beat_be(w_in_off, w_in_size, 2'd0);
                            r_wl   <= w_in_store ? beat_wl(w_in_off, w_in_size, 2'd0, wdata_i) : '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_req) begin
                        if (ram_done_i) begin
                            r_asm <= w_asm_nxt;
                            r_req <= 1'b0;
                            if (!w_last) r_beat <= r_beat + 2'd1;
                        end
                    end else begin
                        r_req  <= 1'b1;
                        r_addr <= r_base + ADDR_W'(int'(r_beat) * BUS_BYTES);
                        r_be   <= beat_be(r_off, r_size, r_beat);
                        r_wl   <= r_we ? beat_wl(r_off, r_size, r_beat, r_sdata) : '0;
                    end
                end
                S_DONE: begin
                    if (!hold_i) r_mis <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        if (rst) begin
            wd_o    = `NOPRegAddr;
            wreg_o  = 1'b0;
            wdata_o = 32'h0;
        end else begin
            case (r_state)
                S_IDLE:   stall_req_o = w_in_mem;
                S_ACCESS: stall_req_o = 1'b1;
                S_DONE: begin
                    misalign_o = r_mis;
                    if (r_mis)       wreg_o  = 1'b0;
                    else if (r_load) wdata_o = w_ext;
                end
                default: ;
            endcase
        end
    end

    assign ram_req_o   = r_req;
    assign ram_we_o    = r_we;
    assign ram_addr_o  = r_addr;
    assign ram_be_o    = r_be;
    assign ram_wdata_o = r_wl;

endmodule
